// File: rtl/frame_rd_arbiter.sv
// ============================================================================
// Module   : frame_rd_arbiter
// Brief    : Round-robin burst arbiter for the shared frame-memory read port.
//            Optional macro FRAME_ARB_PRIO0_EN gives requester 0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_REQ-1:0]          done,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LE_W  = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               rdv_q;

    logic               w_found;
    logic [PTR_W-1:0]   w_pick;
    logic [ADDR_W-1:0]  w_base_sel;
    logic [LEN_W-1:0]   w_len_sel;
    logic [LE_W-1:0]    w_len_eff;
    logic               w_last_beat;
    logic [NUM_REQ-1:0] w_win_oh;

    // Search starts at the pointer and wraps; the first set request wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`ifdef FRAME_ARB_PRIO0_EN
            if (!w_found && idx != 0 && req[idx]) begin
`else
            if (!w_found && req[idx]) begin
`endif
                w_found = 1'b1;
                w_pick  = PTR_W'(idx);
            end
        end
`ifdef FRAME_ARB_PRIO0_EN
        if (req[0]) begin
            w_found = 1'b1;
            w_pick  = '0;
        end
`endif
    end

    always_comb begin
        w_base_sel = '0;
        w_len_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == PTR_W'(i)) begin
                w_base_sel = req_addr[i*ADDR_W +: ADDR_W];
                w_len_sel  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_len_eff   = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
    assign w_last_beat = ({1'b0, cnt_q} == (w_len_eff - LE_W'(1)));
    assign w_win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    win_d   = w_pick;
                    base_d  = w_base_sel;
                    len_d   = w_len_sel;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                cnt_d = cnt_q + LEN_W'(1);
                if (w_last_beat) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                ptr_d   = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + PTR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rdv_q   <= (state_q == S_BURST);
        end
    end

    // Read data returns one cycle after each strobe, so the last byte lands in DRAIN.
    assign mem_rd   = (state_q == S_BURST);
    assign mem_addr = mem_rd ? base_q + {{(ADDR_W-LEN_W){1'b0}}, cnt_q} : '0;
    assign gnt      = (state_q != S_IDLE) ? w_win_oh : '0;
    assign rd_valid = rdv_q ? w_win_oh : '0;
    assign done     = (state_q == S_DRAIN) ? w_win_oh : '0;
    assign rd_data  = mem_data;

endmodule

`default_nettype wire

// File: tb/tb_frame_rd_arbiter.sv
// ============================================================================
// Module   : tb_frame_rd_arbiter
// Brief    : Scoreboard bench for frame_rd_arbiter (honours FRAME_ARB_PRIO0_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int DW = 8;
    localparam int LW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt, rd_valid, done;
    logic [DW-1:0]   rd_data;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int       idx;
        logic [7:0] data;
        bit       last;
    } beat_t;

    beat_t         exp_beats[$];
    logic [AW-1:0] exp_addr[$];
    int            exp_order[$];

    frame_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .done     (done),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h5A;
    endfunction

    // Memory model: data valid the cycle after the strobe.
    always @(posedge clk) if (mem_rd) mem_data <= mem_byte(mem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [AW-1:0] base_of(input int j);
        return AW'((j + 1) * 32'h1000);
    endfunction

    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (gnt != '0) check("gnt_onehot", {63'b0, $onehot(gnt)}, 64'd1);
        if (mem_rd === 1'b1) begin
            if (exp_addr.size() == 0) check("addr_unexpected", 64'd1, 64'd0);
            else check("mem_addr", mem_addr, exp_addr.pop_front());
        end
        if (rd_valid !== '0) begin
            check("rd_lag", {63'b0, prev_rd}, 64'd1);
            if (exp_beats.size() == 0) begin
                check("beat_unexpected", rd_valid, 64'd0);
            end else begin
                beat_t b;
                b = exp_beats.pop_front();
                check("rd_valid", rd_valid, 64'(1 << b.idx));
                check("rd_data", rd_data, b.data);
                check("done", done, b.last ? 64'(1 << b.idx) : 64'd0);
                check("rd_in_gnt", rd_valid & gnt, rd_valid);
            end
        end else if (done !== '0) begin
            check("done_stray", done, 64'd0);
        end
        prev_rd = mem_rd;
    end

    task automatic push_burst(input int idx, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int le;
        le = (len == '0) ? 64 : int'(len);
        for (int k = 0; k < le; k++) begin
            logic [AW-1:0] a;
            a = addr + AW'(k);
            exp_addr.push_back(a);
            exp_beats.push_back('{idx, mem_byte(a), (k == le - 1)});
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_beats_left"}, exp_beats.size(), 64'd0);
        check({tag, "_addr_left"}, exp_addr.size(), 64'd0);
    endtask

    // One burst; inputs are scrambled mid-burst to prove they are ignored.
    task automatic do_burst(input logic [N-1:0] mask, input int idx,
                            input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int le, cyc, gcnt;
        le = (len == '0) ? 64 : int'(len);
        push_burst(idx, addr, len);
        for (int j = 0; j < N; j++) begin
            if (mask[j]) begin
                req_addr[j*AW +: AW] = (j == idx) ? addr : (addr ^ 18'h2AAAA);
                req_len[j*LW +: LW]  = len;
            end
        end
        req = mask;
        cyc = 0;
        while (gnt == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("gnt_winner", gnt, 64'(1 << idx));
        req  = '0;
        gcnt = 0;
        while (gnt[idx] && gcnt < 100) begin
            gcnt++;
            if (gcnt == 3) begin
                req_addr[idx*AW +: AW] = ~addr;
                req_len[idx*LW +: LW]  = len + LW'(5);
            end
            @(negedge clk);
        end
        check("gnt_cycles", gcnt, 64'(le + 1));
        check_drained("burst");
    endtask

    // Holds mask, checks grant order from exp_order and spacing between grants.
    task automatic run_order(input logic [N-1:0] mask, input logic [LW-1:0] len);
        int n, got, cyc, last_start;
        logic [N-1:0] prev_g;
        n = exp_order.size();
        for (int j = 0; j < N; j++) begin
            req_addr[j*AW +: AW] = base_of(j);
            req_len[j*LW +: LW]  = len;
        end
        foreach (exp_order[o]) push_burst(exp_order[o], base_of(exp_order[o]), len);
        req        = mask;
        got        = 0;
        cyc        = 0;
        last_start = 0;
        prev_g     = '0;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0 && prev_g == '0) begin
                check("order_gnt", gnt, 64'(1 << exp_order[got]));
                if (got > 0) check("order_gap", cyc - last_start, 64'(int'(len) + 2));
                last_start = cyc;
                got++;
                if (got == n) req = '0;
            end
            prev_g = gnt;
        end
        check("order_count", got, 64'(n));
        cyc = 0;
        while (gnt != '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check_drained("order");
        exp_order.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 64'd0);
        check({tag, "_rd_valid"}, rd_valid, 64'd0);
        check({tag, "_done"}, done, 64'd0);
        check({tag, "_mem_rd"}, {63'b0, mem_rd}, 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        @(negedge clk);
        apply_reset();

        exp_order = '{0, 1, 2, 3, 0};
        run_order(4'b1111, 6'd2);

        do_burst(4'b0010, 1, 18'h00100, 6'd4);
        do_burst(4'b0001, 0, 18'h3FFFE, 6'd0);
        do_burst(4'b0100, 2, 18'h01234, 6'd8);

        // Reset at beat 5 of a 10-beat burst: 5 strobes, only 4 bytes return.
        for (int k = 0; k < 5; k++) exp_addr.push_back(18'h20000 + AW'(k));
        for (int k = 0; k < 4; k++)
            exp_beats.push_back('{3, mem_byte(18'h20000 + AW'(k)), 1'b0});
        req_addr[3*AW +: AW] = 18'h20000;
        req_len[3*LW +: LW]  = 6'd10;
        req = 4'b1000;
        cyc = 0;
        while (gnt == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_gnt", gnt, 64'h8);
        req = '0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        reset = 1'b0;
        check_drained("midrst");
        @(negedge clk);
        do_burst(4'b1010, 1, 18'h00400, 6'd3);

        apply_reset();
`ifdef FRAME_ARB_PRIO0_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 2, 0, 2};
`endif
        run_order(4'b0101, 6'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
